// File: rtl/sa_inst_scheduler_if.sv
// Issue channel between the instruction scheduler and the systolic array.
// The scheduler drives the instruction word and its issue strobe; the array
// answers with a completion pulse for the instruction in flight.
interface sa_inst_scheduler_if #(
   parameter int INST_BITS = 128
);
   logic [INST_BITS-1:0] instruction;
   logic                 init_inst_pulse;
   logic                 flag;

   modport master (
      output instruction,
      output init_inst_pulse,
      input  flag
   );

   modport slave (
      input  instruction,
      input  init_inst_pulse,
      output flag
   );
endinterface

// File: rtl/sa_inst_scheduler.sv
// Instruction scheduler for the systolic array. A host loads a program into
// local RAM while idle; on start the program is fetched and decoded in order.
// Compute/memory opcodes are issued to the array and waited on with a
// watchdog; NOP, a single-level LOOP and HALT are resolved locally.
module sa_inst_scheduler #(
   parameter int INST_BITS      = 128,
   parameter int PC_DEPTH       = 1024,
   parameter int PC_BITS        = $clog2(PC_DEPTH),
   parameter int OPCODE_BITS    = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wr_en,
   input  logic [PC_BITS-1:0]   wr_addr,
   input  logic [INST_BITS-1:0] wr_data,
   input  logic                 start,
   input  logic                 abort,
   sa_inst_scheduler_if.master  sa,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [PC_BITS-1:0]   pc
);

   localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [OPCODE_BITS-1:0] OP_NOP  = OPCODE_BITS'(0);
   localparam logic [OPCODE_BITS-1:0] OP_LOOP = OPCODE_BITS'(14);
   localparam logic [OPCODE_BITS-1:0] OP_HALT = OPCODE_BITS'(15);

   localparam logic [PC_BITS-1:0] PC_LAST = PC_BITS'(PC_DEPTH - 1);
   localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT,
      S_FINISH
   } state_t;

   state_t               state, state_n;
   logic [PC_BITS-1:0]   pc_n;
   logic                 error_n;
   logic [15:0]          loop_cnt, loop_cnt_n;
   logic                 loop_active, loop_active_n;
   logic [WD_BITS-1:0]   watchdog, watchdog_n;
   logic [INST_BITS-1:0] inst_q, inst_n;
   logic                 advance;

   logic [INST_BITS-1:0] mem [PC_DEPTH];
   logic [INST_BITS-1:0] rd_data;

   logic [OPCODE_BITS-1:0] opcode;
   logic [PC_BITS-1:0]     loop_target;
   logic [15:0]            loop_count;

   assign opcode      = rd_data[INST_BITS-1 -: OPCODE_BITS];
   assign loop_target = rd_data[PC_BITS-1:0];
   assign loop_count  = rd_data[47:32];

   // Program RAM, never reset so a mid-run reset keeps the loaded program.
   // Writes are only accepted while idle; the read issued in FETCH therefore
   // always sees any write made up to and including the start cycle.
   always_ff @(posedge clk) begin
      if (wr_en && (state == S_IDLE)) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[pc];
   end

   // Control state and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         pc          <= '0;
         error       <= 1'b0;
         loop_cnt    <= '0;
         loop_active <= 1'b0;
         watchdog    <= '0;
         inst_q      <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         error       <= error_n;
         loop_cnt    <= loop_cnt_n;
         loop_active <= loop_active_n;
         watchdog    <= watchdog_n;
         inst_q      <= inst_n;
      end
   end

   // Next-state logic; abort overrides everything while a run is in progress,
   // and every sequential pc step funnels through one overrun check.
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      error_n       = error;
      loop_cnt_n    = loop_cnt;
      loop_active_n = loop_active;
      watchdog_n    = watchdog;
      inst_n        = inst_q;
      advance       = 1'b0;

      if (abort && (state != S_IDLE) && (state != S_FINISH)) begin
         state_n = S_FINISH;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state_n       = S_FETCH;
                  pc_n          = '0;
                  error_n       = 1'b0;
                  loop_active_n = 1'b0;
               end
            end
            S_FETCH: begin
               state_n = S_DECODE;
            end
            S_DECODE: begin
               if (opcode == OP_HALT) begin
                  state_n = S_FINISH;
               end else if (opcode == OP_NOP) begin
                  advance = 1'b1;
               end else if (opcode == OP_LOOP) begin
                  if (!loop_active) begin
                     if (loop_count == '0) begin
                        advance = 1'b1;
                     end else begin
                        loop_cnt_n    = loop_count - 16'd1;
                        loop_active_n = 1'b1;
                        pc_n          = loop_target;
                        state_n       = S_FETCH;
                     end
                  end else begin
                     if (loop_cnt == '0) begin
                        loop_active_n = 1'b0;
                        advance       = 1'b1;
                     end else begin
                        loop_cnt_n = loop_cnt - 16'd1;
                        pc_n       = loop_target;
                        state_n    = S_FETCH;
                     end
                  end
               end else begin
                  inst_n  = rd_data;
                  state_n = S_ISSUE;
               end
            end
            S_ISSUE: begin
               watchdog_n = '0;
               state_n    = S_WAIT;
            end
            S_WAIT: begin
               if (sa.flag) begin
                  advance = 1'b1;
               end else if (watchdog == WD_LAST) begin
                  watchdog_n = watchdog + WD_BITS'(1);
                  error_n    = 1'b1;
                  state_n    = S_FINISH;
               end else begin
                  watchdog_n = watchdog + WD_BITS'(1);
               end
            end
            S_FINISH: begin
               state_n = S_IDLE;
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase

         if (advance) begin
            if (pc == PC_LAST) begin
               error_n = 1'b1;
               state_n = S_FINISH;
            end else begin
               pc_n    = pc + PC_BITS'(1);
               state_n = S_FETCH;
            end
         end
      end
   end

   assign busy               = (state != S_IDLE);
   assign done               = (state == S_FINISH);
   assign sa.init_inst_pulse = (state == S_ISSUE);
   assign sa.instruction     = inst_q;

endmodule

// File: tb/tb_sa_inst_scheduler.sv
// Bench for sa_inst_scheduler: small 4-word program RAM and a 16-cycle
// watchdog, random programs compared against an instruction-level model.
module tb_sa_inst_scheduler;

   localparam int INST_BITS = 128;
   localparam int PC_DEPTH  = 4;
   localparam int PC_BITS   = 2;
   localparam int TIMEOUT   = 16;

   logic                 clk     = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 wr_en   = 1'b0;
   logic [PC_BITS-1:0]   wr_addr = '0;
   logic [INST_BITS-1:0] wr_data = '0;
   logic                 start   = 1'b0;
   logic                 abort   = 1'b0;
   logic                 busy, done, error;
   logic [PC_BITS-1:0]   pc;
   logic                 resp_flag   = 1'b0;
   logic                 manual_flag = 1'b0;

   sa_inst_scheduler_if #(.INST_BITS(INST_BITS)) sa_if ();
   assign sa_if.flag = resp_flag | manual_flag;

   sa_inst_scheduler #(
      .INST_BITS(INST_BITS),
      .PC_DEPTH(PC_DEPTH),
      .OPCODE_BITS(4),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .start(start),
      .abort(abort),
      .sa(sa_if.master),
      .busy(busy),
      .done(done),
      .error(error),
      .pc(pc)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;
   int run_start = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Array model: answers each issue pulse with a flag flag_delay cycles later.
   int flag_delay = 0;
   int due = -1;
   always @(negedge clk) begin
      resp_flag = (due >= 0) && (cyc == due);
      if (resp_flag) due = -1;
      if (sa_if.init_inst_pulse && (flag_delay > 0)) due = cyc + flag_delay;
   end

   // Monitor: records issue pulses and done pulses with their cycle numbers.
   int                   pulse_cyc[$];
   logic [INST_BITS-1:0] pulse_word[$];
   int                   done_cnt = 0;
   int                   done_cyc = 0;
   logic                 done_err = 1'b0;
   always @(negedge clk) begin
      if (sa_if.init_inst_pulse) begin
         pulse_cyc.push_back(cyc);
         pulse_word.push_back(sa_if.instruction);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         done_err = error;
      end
   end

   // Reference program image and expected results.
   logic [INST_BITS-1:0] prog [PC_DEPTH];
   int                   exp_cyc[$];
   logic [INST_BITS-1:0] exp_word[$];
   int                   exp_done;
   logic                 exp_err;

   function automatic logic [INST_BITS-1:0] randWord();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [INST_BITS-1:0] withOp(logic [INST_BITS-1:0] w, logic [3:0] op);
      logic [INST_BITS-1:0] r;
      r = w;
      r[INST_BITS-1 -: 4] = op;
      return r;
   endfunction

   function automatic logic [INST_BITS-1:0] saOp();
      return withOp(randWord(), 4'($urandom_range(1, 13)));
   endfunction

   function automatic logic [INST_BITS-1:0] loopWord(int tgt, int cnt);
      logic [INST_BITS-1:0] r;
      r = withOp(randWord(), 4'hE);
      r[47:32] = 16'(cnt);
      r[1:0]   = 2'(tgt);
      return r;
   endfunction

   // Instruction-level interpreter: each local instruction costs two cycles,
   // an issued one costs fetch+decode+issue and then waits for its flag.
   // Times are relative to the cycle in which start is driven.
   task automatic runModel(input int d);
      int t, p, lc, nt, cnt, tgt;
      bit la;
      logic [3:0] op;
      t = 1; p = 0; lc = 0; la = 0;
      exp_cyc.delete();
      exp_word.delete();
      exp_err  = 1'b0;
      exp_done = 0;
      for (int guard = 0; guard < 100; guard++) begin
         op = prog[p][INST_BITS-1 -: 4];
         if (op == 4'hF) begin
            exp_done = t + 2;
            return;
         end
         nt = t + 2;
         if (op == 4'hE) begin
            cnt = int'(prog[p][47:32]);
            tgt = int'(prog[p][1:0]);
            if (!la && cnt != 0) begin
               la = 1; lc = cnt - 1; p = tgt; t = nt;
               continue;
            end
            if (la && lc != 0) begin
               lc--; p = tgt; t = nt;
               continue;
            end
            la = 0;
         end else if (op != 4'h0) begin
            exp_cyc.push_back(t + 2);
            exp_word.push_back(prog[p]);
            if (d == 0) begin
               exp_err  = 1'b1;
               exp_done = t + 3 + TIMEOUT;
               return;
            end
            nt = t + 3 + d;
         end
         if (p == PC_DEPTH - 1) begin
            exp_err  = 1'b1;
            exp_done = nt;
            return;
         end
         p++;
         t = nt;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [INST_BITS-1:0] obs,
                              input logic [INST_BITS-1:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic writeWord(input int a, input logic [INST_BITS-1:0] w);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = PC_BITS'(a);
      wr_data = w;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic loadProgram(input logic [INST_BITS-1:0] w0, input logic [INST_BITS-1:0] w1,
                              input logic [INST_BITS-1:0] w2, input logic [INST_BITS-1:0] w3);
      prog[0] = w0; prog[1] = w1; prog[2] = w2; prog[3] = w3;
      for (int i = 0; i < PC_DEPTH; i++) writeWord(i, prog[i]);
   endtask

   // Pulses start; returns at the negedge of the first FETCH cycle.
   task automatic beginRun(input int d);
      @(negedge clk);
      pulse_cyc.delete();
      pulse_word.delete();
      done_cnt   = 0;
      due        = -1;
      flag_delay = d;
      start      = 1'b1;
      run_start  = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Runs the loaded program to completion and compares against the model.
   task automatic applyStimulus(input int d, input int budget, input string tag);
      runModel(d);
      beginRun(d);
      for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checkOutput($sformatf("%s pulse_count", tag), INST_BITS'(pulse_cyc.size()),
                  INST_BITS'(exp_cyc.size()));
      for (int i = 0; i < exp_cyc.size() && i < pulse_cyc.size(); i++) begin
         checkOutput($sformatf("%s pulse%0d_cycle", tag, i),
                     INST_BITS'(pulse_cyc[i] - run_start), INST_BITS'(exp_cyc[i]));
         checkOutput($sformatf("%s pulse%0d_word", tag, i), pulse_word[i], exp_word[i]);
      end
      checkOutput($sformatf("%s done_count", tag), INST_BITS'(done_cnt), INST_BITS'(1));
      checkOutput($sformatf("%s done_cycle", tag), INST_BITS'(done_cyc - run_start),
                  INST_BITS'(exp_done));
      checkOutput($sformatf("%s error", tag), INST_BITS'(done_err), INST_BITS'(exp_err));
      checkOutput($sformatf("%s busy_after", tag), INST_BITS'(busy), '0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      logic [INST_BITS-1:0] halt_w, nop_w, op_a;
      int d;

      halt_w = withOp(randWord(), 4'hF);
      nop_w  = withOp(randWord(), 4'h0);

      $display("[TB] reset values");
      repeat (2) @(negedge clk);
      checkOutput("reset instruction", sa_if.instruction, '0);
      checkOutput("reset pulse", INST_BITS'(sa_if.init_inst_pulse), '0);
      checkOutput("reset busy", INST_BITS'(busy), '0);
      checkOutput("reset done", INST_BITS'(done), '0);
      checkOutput("reset error", INST_BITS'(error), '0);
      checkOutput("reset pc", INST_BITS'(pc), '0);
      reset_n = 1'b1;

      $display("[TB] two issued ops then HALT");
      op_a = withOp(randWord(), 4'h1);
      loadProgram(op_a, withOp(randWord(), 4'h2), halt_w, nop_w);
      applyStimulus(5, 200, "progA");

      $display("[TB] LOOP count=2 and count=0");
      loadProgram(saOp(), loopWord(0, 2), halt_w, nop_w);
      applyStimulus(int'($urandom_range(1, 8)), 300, "loop2");
      loadProgram(saOp(), loopWord(0, 0), halt_w, nop_w);
      applyStimulus(int'($urandom_range(1, 8)), 300, "loop0");

      $display("[TB] random programs");
      for (int r = 0; r < 6; r++) begin
         case ($urandom_range(0, 2))
            0:       prog[1] = loopWord(0, int'($urandom_range(0, 3)));
            1:       prog[1] = nop_w;
            default: prog[1] = saOp();
         endcase
         loadProgram(saOp(), prog[1], ($urandom_range(0, 1) != 0) ? saOp() : nop_w,
                     ($urandom_range(0, 3) != 0) ? halt_w : nop_w);
         applyStimulus(int'($urandom_range(1, 8)), 400, $sformatf("rand%0d", r));
      end

      $display("[TB] watchdog timeout and late flag");
      loadProgram(saOp(), halt_w, nop_w, nop_w);
      applyStimulus(0, 80, "timeout");
      manual_flag = 1'b1;
      repeat (2) @(negedge clk);
      manual_flag = 1'b0;
      @(negedge clk);
      checkOutput("late_flag busy", INST_BITS'(busy), '0);
      checkOutput("late_flag error", INST_BITS'(error), INST_BITS'(1));
      checkOutput("late_flag pulses", INST_BITS'(pulse_cyc.size()), INST_BITS'(1));
      checkOutput("late_flag done_count", INST_BITS'(done_cnt), INST_BITS'(1));

      $display("[TB] abort during WAIT");
      beginRun(0);
      checkOutput("abort error_cleared", INST_BITS'(error), '0);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort done", INST_BITS'(done), INST_BITS'(1));
      @(negedge clk);
      checkOutput("abort busy_after", INST_BITS'(busy), '0);
      checkOutput("abort done_after", INST_BITS'(done), '0);
      checkOutput("abort error_kept", INST_BITS'(error), '0);
      checkOutput("abort pulses", INST_BITS'(pulse_cyc.size()), INST_BITS'(1));
      applyStimulus(int'($urandom_range(1, 8)), 200, "after_abort");

      $display("[TB] pc overrun and writes while busy");
      loadProgram(nop_w, withOp(randWord(), 4'h0), nop_w, nop_w);
      fork
         applyStimulus(3, 200, "overrun");
         begin
            repeat (2) @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 2'd3;
            wr_data = halt_w;
            @(negedge clk);
            wr_en = 1'b0;
         end
      join
      applyStimulus(3, 200, "overrun_readback");

      $display("[TB] reset during WAIT");
      loadProgram(nop_w, saOp(), halt_w, nop_w);
      d = int'($urandom_range(1, 8));
      applyStimulus(d, 200, "prereset");
      beginRun(0);
      repeat (6) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midreset instruction", sa_if.instruction, '0);
      checkOutput("midreset pulse", INST_BITS'(sa_if.init_inst_pulse), '0);
      checkOutput("midreset busy", INST_BITS'(busy), '0);
      checkOutput("midreset done", INST_BITS'(done), '0);
      checkOutput("midreset error", INST_BITS'(error), '0);
      checkOutput("midreset pc", INST_BITS'(pc), '0);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(d, 200, "postreset");

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/sa_inst_scheduler.md
# sa_inst_scheduler

Instruction scheduler for the systolic array. Holds a host-loaded program in local instruction RAM. On `start` it fetches and decodes instructions in order. Compute/memory instructions are issued to `SYSTOLIC_ARRAY_AXI4_FULL` through the `instruction` / `init_inst_pulse` / `flag` handshake, with a completion watchdog. NOP, single-level LOOP and HALT are handled locally, never forwarded.

## Interface
- `INST_BITS`, 128, instruction width
- `PC_DEPTH`, 1024, instruction RAM depth; `PC_BITS = $clog2(PC_DEPTH)`
- `OPCODE_BITS`, 4, opcode field = `instruction[INST_BITS-1 -: OPCODE_BITS]`
- `TIMEOUT_CYCLES`, 65535, maximum WAIT cycles before error
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `wr_en`  in  1  host RAM write strobe (ignored while `busy`)
- `wr_addr`  in  PC_BITS  host write address
- `wr_data`  in  INST_BITS  host write data
- `start`  in  1  one-cycle pulse; run from address 0 (ignored while `busy`)
- `abort`  in  1  synchronous abort, any state
- `flag`  in  1  SA completion pulse for the issued instruction
- `instruction`  out  INST_BITS  registered instruction to SA
- `init_inst_pulse`  out  1  one-cycle issue strobe
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at program end
- `error`  out  1  sticky until next `start`: timeout or PC overrun
- `pc`  out  PC_BITS  current fetch address

## Operation
- Opcodes: 4'h0 NOP, 4'hE LOOP, 4'hF HALT; all others are issued to the SA.
- LOOP fields: target = `[PC_BITS-1:0]`, count = `[47:32]`.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, FINISH.
- IDLE --start--> FETCH: pc=0, error=0, loop_active=0.
- FETCH: RAM address = pc (synchronous read, 1-cycle latency) -> DECODE.
- DECODE, HALT -> FINISH.
- DECODE, NOP -> pc+1 -> FETCH.
- DECODE, LOOP, not loop_active:
  - count==0 -> pc+1.
  - else loop_cnt=count-1, loop_active=1, pc=target.
- DECODE, LOOP, loop_active:
  - loop_cnt==0 -> loop_active=0, pc+1.
  - else loop_cnt-1, pc=target.
- LOOP net effect: body runs count+1 times. Only one loop level exists. A second LOOP inside an active loop is treated as the same counter.
- DECODE, other opcode -> latch RAM word into `instruction` -> ISSUE.
- ISSUE: `init_inst_pulse`=1 for exactly this cycle; watchdog cleared -> WAIT.
- WAIT:
  - `flag`=1 -> pc+1 -> FETCH.
  - Watchdog reaches TIMEOUT_CYCLES -> error=1 -> FINISH.
- Any pc+1 from pc=PC_DEPTH-1: no wrap; error=1 -> FINISH.
- FINISH: `done`=1 for one cycle -> IDLE.
- `abort` has priority over every transition:
  - Next state is FINISH with `done` pulsed; error unchanged.
  - In IDLE, abort is ignored.
- `flag` outside WAIT is ignored; a flag that arrives late after a timeout is not counted.
- `wr_en` and `start` in the same IDLE cycle: the write completes and the run starts; the fetch at address 0 sees the new data if wr_addr==0 (write-first RAM).

## Timing
- Reset values:
  - `instruction`=0, `init_inst_pulse`=0, `busy`=0, `done`=0, `error`=0, `pc`=0.
  - State IDLE, loop_cnt=0, loop_active=0, watchdog=0.
- `start` sampled at edge 0 -> FETCH at cycle 1 -> DECODE at cycle 2 -> ISSUE at cycle 3 (`init_inst_pulse` high).
- `instruction` is valid from the ISSUE cycle and held stable until the next ISSUE.
- `flag` sampled at edge k in WAIT -> FETCH at k+1 -> next issue pulse at k+3 minimum.
- Cost per local instruction: NOP or LOOP = 2 cycles.
- WAIT timeout: error asserts on the edge where the watchdog equals TIMEOUT_CYCLES. Watchdog is 0 in the first WAIT cycle.
- `done` is high in the FINISH cycle; `busy` drops the cycle after.
- `reset_n` low mid-run: all outputs return to reset values immediately (asynchronous); RAM contents are preserved.

## Test plan
- RAM = {opA 4'h1, opB 4'h2, HALT}; SA model returns flag 5 cycles after each pulse:
  - exactly 2 `init_inst_pulse`, first at start+3; `instruction` equals opA then opB.
  - then `done` pulse, `error`=0.
- RAM = {op1, LOOP target=0 count=2, HALT}:
  - op1 is issued 3 times, `done` follows, `error`=0.
  - LOOP count=0 variant: op1 is issued once.
- SA model never returns flag, TIMEOUT_CYCLES=16:
  - `error`=1 and `done` 16 cycles after entering WAIT; a late flag is ignored.
- `abort` during WAIT: `done` the next cycle, `busy`=0 after; a new `start` runs from pc=0 with `error` cleared.
- PC_DEPTH=4 with no HALT (4 NOPs): `error`=1 and `done` after pc=3; `wr_en` while `busy` leaves RAM unchanged on readback.
- Assert `reset_n` in WAIT: all outputs go to 0 the same cycle; rerun produces identical results to the first run.
